// File: rtl/fifo_downconv_nx.sv
// fifo_downconv_nx: first-word-fall-through FIFO taking RATIO*OUT_WIDTH-bit words and emitting
// them as RATIO OUT_WIDTH-bit lanes. Define FIFO_DOWNCONV_LEVEL_EN to add the registered level_o port.
module fifo_downconv_nx #(
  parameter int OUT_WIDTH  = 16,
  parameter int RATIO      = 2,
  parameter int RATIO_LOG2 = 1,
  parameter int FIFOSIZE   = 512,
  parameter int CNTR_WIDTH = 9,
  parameter int LSB_FIRST  = 1
`ifdef FIFO_DOWNCONV_LEVEL_EN
  ,
  parameter int LVL_WIDTH  = 11
`endif
) (
  input  logic                       dsp_clk,
  input  logic                       dsp_rst,
  input  logic [RATIO*OUT_WIDTH-1:0] dat_i,
  input  logic                       enq_en_i,
  output logic                       enq_rdy_o,
  input  logic                       clr_i,
  output logic [OUT_WIDTH-1:0]       dat_o,
  input  logic                       deq_en_i,
  output logic                       deq_rdy_o
`ifdef FIFO_DOWNCONV_LEVEL_EN
  ,
  output logic [LVL_WIDTH-1:0]       level_o
`endif
);

  localparam int                  IN_WIDTH  = RATIO * OUT_WIDTH;
  localparam logic [CNTR_WIDTH:0] FULL_CNT  = (CNTR_WIDTH + 1)'(FIFOSIZE);
  localparam logic [CNTR_WIDTH:0] CNT_ZERO  = {(CNTR_WIDTH + 1){1'b0}};
  localparam logic [CNTR_WIDTH:0] CNT_ONE   = (CNTR_WIDTH + 1)'(32'sd1);
  localparam logic [CNTR_WIDTH-1:0] PTR_ZERO = {CNTR_WIDTH{1'b0}};
  localparam logic [CNTR_WIDTH-1:0] PTR_ONE  = CNTR_WIDTH'(32'sd1);
  localparam logic [RATIO_LOG2-1:0] LANE_ZERO = {RATIO_LOG2{1'b0}};
  localparam logic [RATIO_LOG2-1:0] LANE_ONE  = RATIO_LOG2'(32'sd1);
  localparam logic [RATIO_LOG2-1:0] LAST_LANE = RATIO_LOG2'(RATIO - 32'sd1);
  localparam logic                  LSB_FIRST_B = LSB_FIRST[0];

  logic [IN_WIDTH-1:0]   mem_r [FIFOSIZE];
  logic [CNTR_WIDTH-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic [CNTR_WIDTH:0]   count_r, count_nxt_s;
  logic [RATIO_LOG2-1:0] lane_r, lane_nxt_s;
  logic                  enq_acc_s, deq_acc_s, pop_s;

  // Map the logical lane index onto a physical slice of the head word.
  function automatic logic [OUT_WIDTH-1:0] lane_sel(input logic [IN_WIDTH-1:0]   word,
                                                    input logic [RATIO_LOG2-1:0] lane);
    logic [RATIO_LOG2-1:0] idx;
    logic [OUT_WIDTH-1:0]  res;
    if (LSB_FIRST_B) begin
      idx = lane;
    end else begin
      idx = LAST_LANE - lane;
    end
    res = {OUT_WIDTH{1'b0}};
    for (int k = 0; k < RATIO; k++) begin
      if (idx == RATIO_LOG2'(k)) begin
        res = word[k*OUT_WIDTH +: OUT_WIDTH];
      end
    end
    return res;
  endfunction

  // Handshake decode; ready flags are held low throughout reset.
  always_comb begin
    enq_rdy_o = 1'b0;
    deq_rdy_o = 1'b0;
    if (dsp_rst) begin
      enq_rdy_o = 1'b0;
      deq_rdy_o = 1'b0;
    end else begin
      enq_rdy_o = (count_r != FULL_CNT);
      deq_rdy_o = (count_r != CNT_ZERO);
    end
    enq_acc_s = enq_en_i && enq_rdy_o;
    deq_acc_s = deq_en_i && deq_rdy_o;
    pop_s     = deq_acc_s && (lane_r == LAST_LANE);
  end

  // Next pointer/occupancy/lane state; flush discards any same-cycle enqueue or dequeue.
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    lane_nxt_s   = lane_r;
    if (dsp_rst || clr_i) begin
      wr_ptr_nxt_s = PTR_ZERO;
      rd_ptr_nxt_s = PTR_ZERO;
      count_nxt_s  = CNT_ZERO;
      lane_nxt_s   = LANE_ZERO;
    end else begin
      if (enq_acc_s) begin
        wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        lane_nxt_s   = LANE_ZERO;
      end else if (deq_acc_s) begin
        rd_ptr_nxt_s = rd_ptr_r;
        lane_nxt_s   = lane_r + LANE_ONE;
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
        lane_nxt_s   = lane_r;
      end
      case ({enq_acc_s, pop_s})
        2'b10:   count_nxt_s = count_r + CNT_ONE;
        2'b01:   count_nxt_s = count_r - CNT_ONE;
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge dsp_clk) begin
    wr_ptr_r <= wr_ptr_nxt_s;
    rd_ptr_r <= rd_ptr_nxt_s;
    count_r  <= count_nxt_s;
    lane_r   <= lane_nxt_s;
  end

  // Storage write port; contents are deliberately left unreset.
  always_ff @(posedge dsp_clk) begin
    if (enq_acc_s && !clr_i) begin
      mem_r[wr_ptr_r] <= dat_i;
    end
  end

  // Fall-through read of the current lane of the head entry.
  always_comb begin
    dat_o = {OUT_WIDTH{1'b0}};
    if (deq_rdy_o) begin
      dat_o = lane_sel(mem_r[rd_ptr_r], lane_r);
    end else begin
      dat_o = {OUT_WIDTH{1'b0}};
    end
  end

`ifdef FIFO_DOWNCONV_LEVEL_EN
  logic [LVL_WIDTH-1:0] level_r, level_nxt_s;

  // Output words remaining, computed from next state so it tracks count/lane on the same edge.
  always_comb begin
    level_nxt_s = LVL_WIDTH'(count_nxt_s) * LVL_WIDTH'(RATIO) - LVL_WIDTH'(lane_nxt_s);
  end

  // Level register.
  always_ff @(posedge dsp_clk) begin
    if (dsp_rst || clr_i) begin
      level_r <= {LVL_WIDTH{1'b0}};
    end else begin
      level_r <= level_nxt_s;
    end
  end

  assign level_o = level_r;
`endif

endmodule

// File: tb/tb_fifo_downconv_nx.sv
// Scoreboard bench for fifo_downconv_nx: default 32->16 LSB-first instance plus a small
// 32->8 MSB-first instance. level_o checks compile in with FIFO_DOWNCONV_LEVEL_EN.
module tb_fifo_downconv_nx;

  logic        dsp_clk = 1'b0;
  logic        dsp_rst = 1'b1;
  logic [31:0] dat_i   = 32'h0;
  logic        enq_en_i = 1'b0;
  logic        deq_en_i = 1'b0;
  logic        clr_i   = 1'b0;
  logic        enq_rdy_o, deq_rdy_o;
  logic [15:0] dat_o;

  logic [31:0] dat4_i   = 32'h0;
  logic        enq4_en  = 1'b0;
  logic        deq4_en  = 1'b0;
  logic        clr4     = 1'b0;
  logic        enq4_rdy, deq4_rdy;
  logic [7:0]  dat4_o;

`ifdef FIFO_DOWNCONV_LEVEL_EN
  logic [10:0] level_o, level4_o;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] sbq[$];
  logic [7:0]  sbq4[$];

  always #5 dsp_clk = ~dsp_clk;

  fifo_downconv_nx u_dut (
    .dsp_clk  (dsp_clk),
    .dsp_rst  (dsp_rst),
    .dat_i    (dat_i),
    .enq_en_i (enq_en_i),
    .enq_rdy_o(enq_rdy_o),
    .clr_i    (clr_i),
    .dat_o    (dat_o),
    .deq_en_i (deq_en_i),
    .deq_rdy_o(deq_rdy_o)
`ifdef FIFO_DOWNCONV_LEVEL_EN
    ,
    .level_o  (level_o)
`endif
  );

  fifo_downconv_nx #(
    .OUT_WIDTH(8), .RATIO(4), .RATIO_LOG2(2), .FIFOSIZE(4), .CNTR_WIDTH(2), .LSB_FIRST(0)
  ) u_dut4 (
    .dsp_clk  (dsp_clk),
    .dsp_rst  (dsp_rst),
    .dat_i    (dat4_i),
    .enq_en_i (enq4_en),
    .enq_rdy_o(enq4_rdy),
    .clr_i    (clr4),
    .dat_o    (dat4_o),
    .deq_en_i (deq4_en),
    .deq_rdy_o(deq4_rdy)
`ifdef FIFO_DOWNCONV_LEVEL_EN
    ,
    .level_o  (level4_o)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One cycle on the default instance: drive, check at negedge, update model at posedge.
  task automatic step(input bit enq, input logic [31:0] d, input bit deq, input bit clr);
    bit exp_enq_rdy, exp_deq_rdy;
    enq_en_i = enq; dat_i = d; deq_en_i = deq; clr_i = clr;
    exp_deq_rdy = (sbq.size() != 0);
    exp_enq_rdy = (((sbq.size() + 1) / 2) != 512);
    @(negedge dsp_clk);
    check_val("enq_rdy", 32'(enq_rdy_o), 32'(exp_enq_rdy));
    check_val("deq_rdy", 32'(deq_rdy_o), 32'(exp_deq_rdy));
    check_val("dat_o", 32'(dat_o), exp_deq_rdy ? 32'(sbq[0]) : 32'h0);
`ifdef FIFO_DOWNCONV_LEVEL_EN
    check_val("level", 32'(level_o), 32'(sbq.size()));
`endif
    @(posedge dsp_clk);
    if (clr) begin
      sbq.delete();
    end else begin
      if (deq && exp_deq_rdy) void'(sbq.pop_front());
      if (enq && exp_enq_rdy) begin
        sbq.push_back(d[15:0]);
        sbq.push_back(d[31:16]);
      end
    end
    #1;
  endtask

  task automatic do_reset();
    dsp_rst = 1'b1; enq_en_i = 1'b0; deq_en_i = 1'b1; clr_i = 1'b0;
    @(posedge dsp_clk);
    sbq.delete();
    @(negedge dsp_clk);
    check_val("rst_enq_rdy", 32'(enq_rdy_o), 32'h0);
    check_val("rst_deq_rdy", 32'(deq_rdy_o), 32'h0);
    check_val("rst_dat_o", 32'(dat_o), 32'h0);
    @(posedge dsp_clk);
    #1;
    dsp_rst = 1'b0; deq_en_i = 1'b0;
    step(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();

    // Basic LSB-first split, dequeue every cycle until empty.
    step(1'b1, 32'hAAAA5555, 1'b0, 1'b0);
    step(1'b1, 32'h12345678, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);

    // MSB-first RATIO=4 instance: 0x11223344 -> 11,22,33,44.
    enq4_en = 1'b1; dat4_i = 32'h11223344;
    @(negedge dsp_clk);
    check_val("d4_rdy_empty", 32'(deq4_rdy), 32'h0);
    @(posedge dsp_clk);
    sbq4.push_back(8'h11); sbq4.push_back(8'h22); sbq4.push_back(8'h33); sbq4.push_back(8'h44);
    #1;
    enq4_en = 1'b0; deq4_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge dsp_clk);
      check_val("d4_rdy", 32'(deq4_rdy), 32'h1);
      check_val("d4_dat", 32'(dat4_o), 32'(sbq4[0]));
`ifdef FIFO_DOWNCONV_LEVEL_EN
      check_val("d4_level", 32'(level4_o), 32'(sbq4.size()));
`endif
      @(posedge dsp_clk);
      void'(sbq4.pop_front());
      #1;
    end
    deq4_en = 1'b0;
    @(negedge dsp_clk);
    check_val("d4_rdy_drained", 32'(deq4_rdy), 32'h0);
`ifdef FIFO_DOWNCONV_LEVEL_EN
    check_val("d4_level_drained", 32'(level4_o), 32'h0);
`endif
    @(posedge dsp_clk);
    #1;

    // Dequeue strobe held while empty, then enqueue: first lane must be BEEF.
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);

    // Flush mid-word together with an enqueue; the enqueued word is dropped.
    step(1'b1, 32'hCAFEF00D, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h99998888, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h00010002, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);

    // Fill to full; extra enqueues ignored, including one alongside the final-lane pop.
    for (int i = 0; i < 512; i++) step(1'b1, {16'(i), 16'(~i)}, 1'b0, 1'b0);
    step(1'b1, 32'hBAD0BAD0, 1'b0, 1'b0);
    step(1'b1, 32'hBAD1BAD1, 1'b1, 1'b0);
    step(1'b1, 32'hBAD2BAD2, 1'b1, 1'b0);
    step(1'b1, 32'h5A5A0001, 1'b0, 1'b0);

    // Random traffic across pointer wrap, then drain.
    for (int i = 0; i < 1200; i++)
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 3000 && sbq.size() != 0; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    check_val("drained", 32'(sbq.size()), 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b0);

    // Reset mid-word with three entries queued.
    step(1'b1, 32'h11112222, 1'b0, 1'b0);
    step(1'b1, 32'h33334444, 1'b0, 1'b0);
    step(1'b1, 32'h55556666, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    do_reset();
    step(1'b1, 32'h77778888, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_downconv_nx.md
Name: fifo_downconv_nx

Overview:
- Parametrised width-down-converting FIFO: accepts RATIO*OUT_WIDTH-bit words and delivers them as RATIO consecutive OUT_WIDTH-bit words.
- Sits between the 32-bit sample/packet path and narrower DSP consumers in the usrp2 glue.
- Generalises the fixed 32-to-16 converter with configurable ratio, depth and lane order, plus a flush input.
- Uses its own storage (no SizedFIFO instance). The lane counter advances only on accepted dequeues.

Parameters:
- OUT_WIDTH, 16: output word width in bits.
- RATIO, 2: output words per input word (>=2). Input width = RATIO*OUT_WIDTH.
- RATIO_LOG2, 1: ceil(log2(RATIO)); width of the lane counter.
- FIFOSIZE, 512: depth in input words; must be a power of two.
- CNTR_WIDTH, 9: log2(FIFOSIZE); read/write pointer width.
- LSB_FIRST, 1: 1 = lane 0 is bits [OUT_WIDTH-1:0] first; 0 = most-significant lane first.

Ports:
- dsp_clk, in, 1: clock; all state updates on the rising edge.
- dsp_rst, in, 1: synchronous, active-high reset.
- dat_i, in, RATIO*OUT_WIDTH: enqueue data.
- enq_en_i, in, 1: enqueue strobe; honoured only when enq_rdy_o=1.
- enq_rdy_o, out, 1: space for one input word.
- clr_i, in, 1: synchronous flush.
- dat_o, out, OUT_WIDTH: current output lane of the head entry.
- deq_en_i, in, 1: consume one output word; honoured only when deq_rdy_o=1.
- deq_rdy_o, out, 1: dat_o valid.

Behaviour:
- State:
  - storage mem[FIFOSIZE] of RATIO*OUT_WIDTH bits;
  - wr_ptr, rd_ptr: CNTR_WIDTH bits, wrap modulo FIFOSIZE;
  - count: CNTR_WIDTH+1 bits, range 0..FIFOSIZE;
  - lane_q: RATIO_LOG2 bits, range 0..RATIO-1.
- Reset (dsp_rst=1 at an edge): wr_ptr=rd_ptr=count=lane_q=0. Memory contents are not reset.
- While dsp_rst=1: enq_rdy_o=0, deq_rdy_o=0, dat_o=0. From the first cycle after reset: enq_rdy_o=1, deq_rdy_o=0, dat_o=0.
- Ready outputs are combinational from registered state:
  - enq_rdy_o = !dsp_rst && count!=FIFOSIZE;
  - deq_rdy_o = !dsp_rst && count!=0.
- Accepted enqueue (enq_en_i && enq_rdy_o): mem[wr_ptr]<=dat_i; wr_ptr++.
- Accepted dequeue (deq_en_i && deq_rdy_o):
  - if lane_q==RATIO-1: rd_ptr++, count--, lane_q<=0;
  - else: lane_q++.
- Strobes while not ready are ignored: no state change, no error.
- Output selection (first-word-fall-through, combinational from mem[rd_ptr]):
  - dat_o = lane L of the head entry, where L = lane_q if LSB_FIRST=1, else RATIO-1-lane_q;
  - lane k = bits [(k+1)*OUT_WIDTH-1 : k*OUT_WIDTH];
  - dat_o=0 whenever deq_rdy_o=0.
- Latency: an enqueue into an empty FIFO raises deq_rdy_o on the next cycle, with dat_o = first lane.
- Simultaneous enqueue and final-lane pop: count unchanged; both pointers advance.
- Full: enq_rdy_o=0 even if the same cycle pops an entry. There is no same-cycle pass-through; space appears the next cycle.
- Empty: an enqueue in the same cycle as a deq_en_i strobe is written; the strobe is ignored.
- Flush: clr_i=1 sets wr_ptr=rd_ptr=count=lane_q=0. It overrides any enqueue or dequeue in the same cycle; both are dropped.
- Flush or reset mid-word: a partially consumed head entry is discarded and the next word starts at lane 0.
- Pointer wrap: FIFOSIZE-1 wraps to 0 with no bubble.

Optional Feature:
- Macro FIFO_DOWNCONV_LEVEL_EN.
- Defined:
  - adds parameter LVL_WIDTH (default 11; must be >= ceil(log2(FIFOSIZE*RATIO+1)));
  - adds output level_o, LVL_WIDTH bits = count*RATIO - lane_q, i.e. the number of output words still available;
  - level_o is registered: it updates on the same edge as count/lane_q, reads 0 after reset or flush, and can be used for burst-read scheduling.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- Defaults, LSB_FIRST=1: enqueue 0xAAAA5555 then 0x12345678; dequeue every cycle -> dat_o = 0x5555, 0xAAAA, 0x5678, 0x1234; deq_rdy_o falls after the 4th accepted dequeue.
- LSB_FIRST=0, RATIO=4, OUT_WIDTH=8: enqueue 0x11223344 -> dat_o = 0x11, 0x22, 0x33, 0x44; level_o (if enabled) = 4, 3, 2, 1, 0.
- Fill to 512 entries -> enq_rdy_o=0; a 513th enq_en_i is ignored. Two dequeues free one entry -> enq_rdy_o=1 next cycle; 600 total words in/out with wrap preserve order.
- deq_en_i held high while empty, then enqueue 0xDEADBEEF -> first valid dat_o = 0xBEEF; lane_q did not advance while empty.
- After one dequeue of 0xCAFEF00D (dat_o now 0xCAFE), assert clr_i together with enq_en_i -> count=0, deq_rdy_o=0, enqueued word dropped. Next enqueue 0x00010002 -> dat_o = 0x0002.
- Assert dsp_rst mid-word with 3 entries queued -> enq_rdy_o=deq_rdy_o=0 during reset; afterwards empty, lane 0, dat_o=0.
